decoder416_seq: RTL and testbench
=================================

// Module: decoder416_seq
// PURPOSE
//  Sequenced 4->16 decoder: the inverse of the 16->4 priority encoder path.
//  Accepts encoded codes (a[3:0] plus a "no line active" flag) through a valid/ready port.
//  Buffers up to DEPTH codes and replays each one as a one-hot pulse on c[15:0].
//  Each pulse lasts HOLD cycles and is followed by GAP idle cycles.
//  Sits downstream of the encoder to regenerate request lines, e.g. for strobing or test replay.
// PARAMETERS
//  AW     4  code width; output width N = 2**AW
//  DEPTH  4  FIFO entries; power of 2, >= 2
//  HOLD   2  cycles each decoded line is held high; >= 1
//  GAP    1  idle cycles between slots; >= 0
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous reset, active-high
//  en        in   1      block enable
//  in_valid  in   1      code present
//  in_ready  out  1      block can accept; = en & !full
//  in_a      in   AW     code; index 0 is the encoder's highest priority
//  in_none   in   1      encoder y flag: no line active; slot replays all-zero
//  c         out  N      one-hot decoded lines, registered
//  c_valid   out  1      high for every cycle of a slot, including blank slots
//  busy      out  1      FSM not IDLE, or FIFO non-empty
//  level     out  AW'    FIFO occupancy, $clog2(DEPTH)+1 bits
// BEHAVIOUR
//  Reset:
//   - At the rst edge: c=0, c_valid=0, FIFO emptied, level=0, FSM=IDLE, counter=0.
//   - rst overrides all other inputs, including mid-slot.
//  Push:
//   - Occurs on an edge with in_valid & in_ready; stores {in_none, in_a}.
//   - When full, in_ready=0; a same-cycle pop never lets a push in while full.
//  Pop:
//   - Only the FSM pops, and only when en=1.
//   - level updates by +1, -1 or 0 for push, pop, or simultaneous push+pop.
//  FSM states: IDLE, DRIVE, GAP.
//   - IDLE: if en & !empty, pop. Next cycle: c = in_none ? 0 : (1<<in_a), c_valid=1, cnt=HOLD-1, state DRIVE.
//   - DRIVE: cnt!=0 -> decrement. cnt==0 -> end of slot:
//       - GAP>0: c=0, c_valid=0, cnt=GAP-1, state GAP.
//       - GAP==0 & !empty: pop and load the next slot back-to-back, stay in DRIVE.
//       - GAP==0 & empty: c=0, c_valid=0, state IDLE.
//   - GAP: cnt!=0 -> decrement. cnt==0 -> if !empty pop and load DRIVE as from IDLE, else IDLE.
//  Latency:
//   - Code pushed at edge E0 into an empty, IDLE block: c valid after edge E1.
//   - The slot stays for exactly HOLD cycles.
//   - Slot period is HOLD+GAP cycles while the FIFO stays non-empty.
//  en=0:
//   - At the next edge: c=0, c_valid=0, FSM=IDLE. The aborted slot is discarded, not replayed.
//   - FIFO contents are kept. in_ready=0.
//  Invariants:
//   - c is one-hot or zero, never multi-hot.
//   - c!=0 implies c_valid=1.
//  Encoder compatibility: code 0 drives c[0], code 15 drives c[15]. No priority logic; one code = one line.
// TESTING
//  1 Reset: assert rst mid-slot holding c=16'h0100 -> next cycle c=0, c_valid=0, level=0, in_ready=1.
//  2 Single: HOLD=2, GAP=1, push a=4'h5 at E0 -> c=16'h0020 after E1 and E2, c=0 after E3, busy=0 after E4.
//  3 Burst/full: DEPTH=4, push 6 codes back-to-back:
//     - in_ready drops when level=4; no code is lost.
//     - Output order 3,7,0,15,1,2 with period HOLD+GAP.
//  4 Back-to-back: GAP=0, push a=1 then a=2 -> c=0002 for HOLD cycles, then immediately c=0004; no zero bubble.
//  5 Blank slot: push in_none=1 between a=0 and a=9 -> c=0001, then c_valid=1 with c=0, then c=0200.
//  6 Enable abort: drop en during the slot for a=6 -> c=0 next edge; remaining FIFO codes replay after en=1.
//     Check: c never multi-hot across all runs.

Source files
------------

// File: rtl/decoder416_seq.sv
// Sequenced 4->16 decoder: buffers encoded codes and replays each as a one-hot pulse on c.
// Latency: code pushed into an empty idle block appears on c one edge later, held HOLD cycles, then GAP idle.
// Backpressure: in_ready = en & !full; en=0 aborts the current slot and stalls both push and pop.

// Small synchronous show-ahead FIFO; head entry is always visible on rd_dat.
// Latency: a pushed entry is visible at rd_dat one edge after the push.
// Backpressure: push is ignored when full, pop is ignored when empty.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wr_dat,
    input  logic          pop,
    output logic [W-1:0]  rd_dat,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_dat  = mem[rd_ptr];

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

module decoder416_seq #(
    parameter int AW    = 4,
    parameter int DEPTH = 4,
    parameter int HOLD  = 2,
    parameter int GAP   = 1,
    localparam int N    = 2 ** AW,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_a,
    input  logic          in_none,
    output logic [N-1:0]  c,
    output logic          c_valid,
    output logic          busy,
    output logic [LW-1:0] level
);

    // Slot counter must hold HOLD-1 and GAP-1.
    localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_GAP
    } state_t;

    typedef struct packed {
        logic          none;
        logic [AW-1:0] a;
    } code_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cnt_zero;

    code_t         push_dat;
    code_t         head;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    assign in_ready      = en && !fifo_full;
    assign push          = in_valid && in_ready;
    assign push_dat.none = in_none;
    assign push_dat.a    = in_a;
    assign cnt_zero      = (cnt == '0);
    assign busy          = (state != S_IDLE) || !fifo_empty;

    fifo #(
        .W     ($bits(code_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_dat (push_dat),
        .pop    (pop),
        .rd_dat (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (level)
    );

    // Pop whenever the FSM is about to start a new slot and a code is waiting.
    always_comb begin
        pop = 1'b0;
        if (en && !fifo_empty) begin
            case (state)
                S_IDLE:  pop = 1'b1;
                S_DRIVE: pop = cnt_zero && (GAP == 0);
                S_GAP:   pop = cnt_zero;
                default: pop = 1'b0;
            endcase
        end
    end

    // Slot sequencer with registered outputs; a pop always coincides with loading the popped code.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            c       <= '0;
            c_valid <= 1'b0;
        end else if (!en) begin
            // Abort: the slot in flight is dropped, queued codes stay in the FIFO.
            state   <= S_IDLE;
            cnt     <= '0;
            c       <= '0;
            c_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        c       <= head.none ? '0 : (N'(1) << head.a);
                        c_valid <= 1'b1;
                        cnt     <= CW'(HOLD - 1);
                        state   <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - CW'(1);
                    end else if (GAP > 0) begin
                        c       <= '0;
                        c_valid <= 1'b0;
                        cnt     <= CW'((GAP > 0) ? GAP - 1 : 0);
                        state   <= S_GAP;
                    end else if (pop) begin
                        // Back-to-back slot: no idle bubble when GAP is zero.
                        c       <= head.none ? '0 : (N'(1) << head.a);
                        c_valid <= 1'b1;
                        cnt     <= CW'(HOLD - 1);
                        state   <= S_DRIVE;
                    end else begin
                        c       <= '0;
                        c_valid <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - CW'(1);
                    end else if (pop) begin
                        c       <= head.none ? '0 : (N'(1) << head.a);
                        c_valid <= 1'b1;
                        cnt     <= CW'(HOLD - 1);
                        state   <= S_DRIVE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    c       <= '0;
                    c_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder416_seq.sv
// Bench for decoder416_seq: table-driven single/blank-slot vectors plus directed corner sequences.
// Two instances share stimulus: u_dut (HOLD=2, GAP=1) and u_dut0 (HOLD=2, GAP=0).
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_decoder416_seq;

    logic        clk;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [3:0]  in_a;
    logic        in_none;

    logic        in_ready;
    logic [15:0] c;
    logic        c_valid;
    logic        busy;
    logic [2:0]  level;

    logic        ready0;
    logic [15:0] c0;
    logic        cv0;
    logic        busy0;
    logic [2:0]  level0;

    int tests = 0;
    int fails = 0;
    int mh_err = 0;

    decoder416_seq #(.AW(4), .DEPTH(4), .HOLD(2), .GAP(1)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_none  (in_none),
        .c        (c),
        .c_valid  (c_valid),
        .busy     (busy),
        .level    (level)
    );

    decoder416_seq #(.AW(4), .DEPTH(4), .HOLD(2), .GAP(0)) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (in_valid),
        .in_ready (ready0),
        .in_a     (in_a),
        .in_none  (in_none),
        .c        (c0),
        .c_valid  (cv0),
        .busy     (busy0),
        .level    (level0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Invariants on both instances: never multi-hot, and a raised line implies c_valid.
    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(c) > 1 || (c != 16'h0 && !c_valid)) mh_err++;
            if ($countones(c0) > 1 || (c0 != 16'h0 && !cv0)) mh_err++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        vld;
        logic [3:0]  a;
        logic        none;
        logic [15:0] c;
        logic        cv;
        logic        busy;
        logic [2:0]  lvl;
    } vec_t;

    function automatic vec_t mk(logic r, logic v, logic [3:0] a, logic n,
                                logic [15:0] ec, logic ecv, logic eb, logic [2:0] el);
        vec_t t;
        t.rst = r; t.vld = v; t.a = a; t.none = n;
        t.c = ec; t.cv = ecv; t.busy = eb; t.lvl = el;
        return t;
    endfunction

    vec_t        tbl [17];
    logic [3:0]  burst [6];
    logic [15:0] burst_exp [6];
    logic [15:0] exp4_c [6];
    logic        exp4_cv [6];

    initial begin
        logic [15:0] seen [$];
        int          starts [$];
        int          pushed;
        int          run;
        int          runerr;
        int          ready_err;
        bit          saw_full;
        bit          acc;
        bit          prev_cv;
        bit          found;
        bit          seen6;

        // Single push a=5 (rows 0-5), then blank slot between a=0 and a=9 (rows 6-16).
        tbl[0]  = mk(1, 0, 4'h0, 0, 16'h0000, 0, 0, 3'd0);
        tbl[1]  = mk(0, 1, 4'h5, 0, 16'h0000, 0, 1, 3'd1);
        tbl[2]  = mk(0, 0, 4'h0, 0, 16'h0020, 1, 1, 3'd0);
        tbl[3]  = mk(0, 0, 4'h0, 0, 16'h0020, 1, 1, 3'd0);
        tbl[4]  = mk(0, 0, 4'h0, 0, 16'h0000, 0, 1, 3'd0);
        tbl[5]  = mk(0, 0, 4'h0, 0, 16'h0000, 0, 0, 3'd0);
        tbl[6]  = mk(0, 1, 4'h0, 0, 16'h0000, 0, 1, 3'd1);
        tbl[7]  = mk(0, 1, 4'h0, 1, 16'h0001, 1, 1, 3'd1);
        tbl[8]  = mk(0, 1, 4'h9, 0, 16'h0001, 1, 1, 3'd2);
        tbl[9]  = mk(0, 0, 4'h0, 0, 16'h0000, 0, 1, 3'd2);
        tbl[10] = mk(0, 0, 4'h0, 0, 16'h0000, 1, 1, 3'd1);
        tbl[11] = mk(0, 0, 4'h0, 0, 16'h0000, 1, 1, 3'd1);
        tbl[12] = mk(0, 0, 4'h0, 0, 16'h0000, 0, 1, 3'd1);
        tbl[13] = mk(0, 0, 4'h0, 0, 16'h0200, 1, 1, 3'd0);
        tbl[14] = mk(0, 0, 4'h0, 0, 16'h0200, 1, 1, 3'd0);
        tbl[15] = mk(0, 0, 4'h0, 0, 16'h0000, 0, 1, 3'd0);
        tbl[16] = mk(0, 0, 4'h0, 0, 16'h0000, 0, 0, 3'd0);

        burst     = '{4'd3, 4'd7, 4'd0, 4'd15, 4'd1, 4'd2};
        burst_exp = '{16'h0008, 16'h0080, 16'h0001, 16'h8000, 16'h0002, 16'h0004};
        exp4_c    = '{16'h0000, 16'h0002, 16'h0002, 16'h0004, 16'h0004, 16'h0000};
        exp4_cv   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_a = 4'h0; in_none = 1'b0;

        // ---- table-driven vectors ----
        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst; in_valid = tbl[i].vld; in_a = tbl[i].a; in_none = tbl[i].none;
            tick;
            check($sformatf("vec%0d_c", i), {16'h0, c}, {16'h0, tbl[i].c});
            check($sformatf("vec%0d_cv", i), {31'h0, c_valid}, {31'h0, tbl[i].cv});
            check($sformatf("vec%0d_busy", i), {31'h0, busy}, {31'h0, tbl[i].busy});
            check($sformatf("vec%0d_level", i), {29'h0, level}, {29'h0, tbl[i].lvl});
            check($sformatf("vec%0d_ready", i), {31'h0, in_ready}, 32'h1);
        end
        in_valid = 1'b0; in_none = 1'b0;

        // ---- reset mid-slot while c=0100 ----
        rst = 1'b1; tick; rst = 1'b0;
        in_valid = 1'b1; in_a = 4'h8; tick;
        in_a = 4'h1; tick;
        in_a = 4'h2; tick;
        in_valid = 1'b0;
        for (int k = 0; k < 10 && c != 16'h0100; k++) tick;
        check("rst_pre_c", {16'h0, c}, 32'h0100);
        check("rst_pre_level", {29'h0, level}, 32'd2);
        rst = 1'b1; tick;
        check("rst_c", {16'h0, c}, 32'h0);
        check("rst_cv", {31'h0, c_valid}, 32'h0);
        check("rst_level", {29'h0, level}, 32'h0);
        check("rst_ready", {31'h0, in_ready}, 32'h1);
        rst = 1'b0; tick; tick;
        check("rst_after_c", {16'h0, c}, 32'h0);
        check("rst_after_busy", {31'h0, busy}, 32'h0);

        // ---- burst of 6 into DEPTH=4 ----
        rst = 1'b1; tick; rst = 1'b0;
        pushed = 0; run = 0; runerr = 0; ready_err = 0; saw_full = 0; prev_cv = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            in_valid = (pushed < 6);
            in_a = burst[(pushed < 6) ? pushed : 0];
            acc = in_valid && in_ready;
            tick;
            if (acc) pushed++;
            if (in_ready !== (level != 3'd4)) ready_err++;
            if (level == 3'd4) saw_full = 1;
            if (c_valid && !prev_cv) begin
                starts.push_back(cyc);
                seen.push_back(c);
            end
            if (c_valid) run++;
            else begin
                if (run != 0 && run != 2) runerr++;
                run = 0;
            end
            prev_cv = c_valid;
        end
        in_valid = 1'b0;
        check("burst_pushed", pushed, 32'd6);
        check("burst_saw_full", {31'h0, saw_full}, 32'h1);
        check("burst_ready_vs_level", ready_err, 32'd0);
        check("burst_hold_len", runerr, 32'd0);
        check("burst_slots", seen.size(), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < seen.size()) check($sformatf("burst_code%0d", k), {16'h0, seen[k]}, {16'h0, burst_exp[k]});
            if (k > 0 && k < starts.size()) check($sformatf("burst_period%0d", k), starts[k] - starts[k-1], 32'd3);
        end

        // ---- back-to-back with GAP=0 on u_dut0 ----
        rst = 1'b1; tick; rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = (k < 2);
            in_a = (k == 0) ? 4'h1 : 4'h2;
            tick;
            check($sformatf("b2b%0d_c", k), {16'h0, c0}, {16'h0, exp4_c[k]});
            check($sformatf("b2b%0d_cv", k), {31'h0, cv0}, {31'h0, exp4_cv[k]});
        end
        in_valid = 1'b0;

        // ---- enable abort during slot for a=6 ----
        rst = 1'b1; tick; rst = 1'b0;
        in_valid = 1'b1; in_a = 4'h6; tick;
        in_a = 4'h4; tick;
        in_a = 4'hb; tick;
        in_valid = 1'b0;
        check("abort_pre_c", {16'h0, c}, 32'h0040);
        en = 1'b0; tick;
        check("abort_c", {16'h0, c}, 32'h0);
        check("abort_cv", {31'h0, c_valid}, 32'h0);
        check("abort_level", {29'h0, level}, 32'd2);
        check("abort_ready", {31'h0, in_ready}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h1);
        tick;
        check("abort_hold_c", {16'h0, c}, 32'h0);
        en = 1'b1; tick;
        check("abort_resume_c", {16'h0, c}, 32'h0010);
        check("abort_resume_cv", {31'h0, c_valid}, 32'h1);
        found = 0; seen6 = 0;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (c == 16'h0040) seen6 = 1;
            if (c == 16'h0800) found = 1;
        end
        check("abort_next_replayed", {31'h0, found}, 32'h1);
        check("abort_not_replayed", {31'h0, seen6}, 32'h0);
        check("abort_drained_busy", {31'h0, busy}, 32'h0);
        check("abort_drained_level", {29'h0, level}, 32'h0);

        check("onehot_invariant", mh_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
